// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
// Handshake: a byte moves on a rising edge where in_valid && in_ready; the source holds in_data stable while in_valid is high and unaccepted.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte image (count, LE words, XOR checksum) into
// instruction-memory writes while holding the core in reset.
module imem_loader #(
  parameter int DEPTH = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  imem_loader_if.master      bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [15:0]        words_loaded,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  state_t      state_next;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic        accept;
  logic        start_ok;
  logic [15:0] len_full;
  logic        next_ready;
  logic        next_hold;

  assign accept    = bus.in_valid && bus.in_ready;
  assign len_full  = {bus.in_data, len[7:0]};
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next = S_LEN_LO;
          start_ok   = 1'b1;
        end
      end
      S_LEN_LO: if (accept) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_full} > DEPTH_W) state_next = S_ERROR;
          else if (len_full == 16'd0)     state_next = S_CHECK;
          else                            state_next = S_DATA;
        end
      end
      S_DATA: if (accept && byte_cnt == 2'd3) state_next = S_WRITE;
      S_WRITE: begin
        if ((words_loaded + 16'd1) == len) state_next = S_CHECK;
        else                               state_next = S_DATA;
      end
      S_CHECK: begin
        if (accept) state_next = (bus.in_data == csum) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    next_ready = 1'b0;
    next_hold  = 1'b0;
    case (state_next)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: begin
        next_ready = 1'b1;
        next_hold  = 1'b1;
      end
      S_WRITE: next_hold = 1'b1;
      default: begin
        next_ready = 1'b0;
        next_hold  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      len           <= 16'd0;
      byte_cnt      <= 2'd0;
      csum          <= 8'd0;
      words_loaded  <= 16'd0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state        <= state_next;
      bus.in_ready <= next_ready;
      bus.mem_we   <= (state_next == S_WRITE);
      cpu_hold     <= next_hold;
      done         <= (state_next == S_DONE);
      error        <= (state_next == S_ERROR);

      if (start_ok) begin
        len          <= 16'd0;
        byte_cnt     <= 2'd0;
        csum         <= 8'd0;
        words_loaded <= 16'd0;
      end

      if (state == S_LEN_LO && accept) len[7:0]  <= bus.in_data;
      if (state == S_LEN_HI && accept) len[15:8] <= bus.in_data;

      if (state == S_DATA && accept) begin
        bus.mem_wdata[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
        csum     <= csum ^ bus.in_data;
        byte_cnt <= byte_cnt + 2'd1;
      end

      if (state == S_DATA && state_next == S_WRITE) begin
        bus.mem_addr <= {14'd0, words_loaded, 2'b00};
      end

      if (state == S_WRITE) words_loaded <= words_loaded + 16'd1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed framed images plus randomized
// images checked against a byte-stream model of the loader.
module tb_imem_loader;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic [2:0]  state_dbg;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 1ms", $time);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img_words[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  logic prev_we = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (bus.mem_we) begin
        check("we_single_cycle", 64'(prev_we), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr_data", {bus.mem_addr, bus.mem_wdata}, e);
        end
        check("ready_low_in_write", 64'(bus.in_ready), 64'd0);
        check("hold_high_in_write", 64'(cpu_hold), 64'd1);
      end
      prev_we = bus.mem_we;
    end
  end

  // ---------------- model ----------------
  function automatic logic [7:0] model_csum(input int n);
    logic [7:0] x;
    x = 8'd0;
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 4; k++) x = x ^ img_words[w][8*k +: 8];
    return x;
  endfunction

  // ---------------- drivers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got no in_ready in %0d cycles required acceptance", t);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_flags"}, 64'({bus.in_ready, bus.mem_we, cpu_hold, done, error}), 64'd0);
    check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  // gap < 0 selects a random 0..3 idle cycles before each byte.
  task automatic run_load(input int n, input bit corrupt, input int gap, input int start_at,
                          input int abort_at, input int exp_cyc, input bit push_model);
    logic [7:0] s[$];
    logic [7:0] cs;
    bit ok_len;
    int nw;
    int c0;
    int c1;
    int t;
    int g;
    bit exp_done;
    bit exp_err;

    ok_len = (n <= DEPTH);
    s = {};
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    cs = 8'd0;
    if (ok_len) begin
      cs = model_csum(n);
      for (int w = 0; w < n; w++)
        for (int k = 0; k < 4; k++) s.push_back(img_words[w][8*k +: 8]);
      s.push_back(corrupt ? (cs ^ 8'h01) : cs);
    end

    if (!ok_len)          nw = 0;
    else if (abort_at >= 0) nw = ((abort_at - 2) / 4 < n) ? (abort_at - 2) / 4 : n;
    else                  nw = n;
    if (push_model)
      for (int w = 0; w < nw; w++) exp_q.push_back({32'(w * 4), img_words[w]});
    exp_done = ok_len && !corrupt;
    exp_err  = !exp_done;

    pulse_start();
    c0 = cyc;
    check("hold_after_start", 64'(cpu_hold), 64'd1);
    check("status_cleared", 64'({done, error, words_loaded}), 64'd0);

    for (int i = 0; i < s.size(); i++) begin
      if (i == abort_at) break;
      if (i == start_at) pulse_start();
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (i > 0) repeat (g) begin @(posedge clk); #1; end
      send_byte(s[i]);
    end

    if (abort_at >= 0) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_values("abort");
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("abort_pending_writes", 64'(exp_q.size()), 64'd0);
      check("abort_quiet", 64'({bus.mem_we, cpu_hold}), 64'd0);
      return;
    end

    if (!ok_len) check("oversize_err_now", 64'({error, bus.in_ready}), 64'b10);

    t = 0;
    @(negedge clk);
    while (!(done || error) && t < 100) begin
      @(negedge clk);
      t++;
    end
    c1 = cyc;
    if (!(done || error)) begin
      checks++;
      errors++;
      $display("FAIL finish_timeout: got no done/error in %0d cycles required one", t);
    end
    check("done", 64'(done), 64'(exp_done));
    check("error", 64'(error), 64'(exp_err));
    check("words_loaded", 64'(words_loaded), 64'(nw));
    check("idle_outputs", 64'({cpu_hold, bus.in_ready}), 64'd0);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    if (exp_cyc >= 0) check("load_cycles", 64'(c1 - c0), 64'(exp_cyc));
    repeat (2) begin @(posedge clk); #1; end
    check("sticky_result", 64'({done, error}), 64'({exp_done, exp_err}));
  endtask

  task automatic set_nominal(input bit push_lit);
    img_words = {32'h00500093, 32'h00108113};
    if (push_lit) begin
      exp_q.push_back({32'h0000_0000, 32'h00500093});
      exp_q.push_back({32'h0000_0004, 32'h00108113});
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    set_nominal(1'b0);
    check("model_csum_pin", 64'(model_csum(2)), 64'h41);

    set_nominal(1'b1);
    run_load(2, 1'b0, 0, -1, -1, 13, 1'b0);          // nominal, restarts from IDLE
    set_nominal(1'b1);
    run_load(2, 1'b1, 0, -1, -1, -1, 1'b0);          // checksum 0x40, start from DONE
    img_words = {};
    run_load(0, 1'b0, 0, -1, -1, 3, 1'b1);           // empty image
    run_load(1025, 1'b0, 0, -1, -1, -1, 1'b1);       // oversize
    set_nominal(1'b1);
    run_load(2, 1'b0, 3, -1, -1, -1, 1'b0);          // backpressure
    set_nominal(1'b0);
    run_load(2, 1'b0, 0, -1, 8, -1, 1'b1);           // reset after 6th data byte
    set_nominal(1'b1);
    run_load(2, 1'b0, 0, -1, -1, 13, 1'b0);          // reload after reset
    set_nominal(1'b1);
    run_load(2, 1'b0, 0, 5, -1, -1, 1'b0);           // start pulsed mid-load

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      img_words = {};
      for (int w = 0; w < n; w++) img_words.push_back($urandom);
      run_load(n, ($urandom_range(0, 3) == 0), -1, -1, -1, -1, 1'b1);
    end

    img_words = {};
    for (int w = 0; w < DEPTH; w++) img_words.push_back($urandom);
    run_load(DEPTH, 1'b0, 0, -1, -1, 2 + 5 * DEPTH + 1, 1'b1);
    run_load(int'($urandom_range(DEPTH + 1, 65535)), 1'b0, 0, -1, -1, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
